// File: rtl/reg_file_pkg.sv
// Shared helpers for the synchronous register file: address-width derivation
// and the per-byte strobe merge used by both the write path and the bypass path.
package reg_file_pkg;

    function automatic int calc_aw(input int depth);
        int a;
        a = $clog2(depth);
        return (a < 1) ? 1 : a;
    endfunction

    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset-release synchronizer: asserts asynchronously, releases after STAGES
// rising clock edges with rst_in low.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_in,
    output logic rst_out
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign rst_out = chain[STAGES-1];

endmodule

// File: rtl/reg_file_sync.sv
// Flop-based register file: one byte-strobed write port, two combinational
// read ports, optional write-to-read forwarding and hardwired-zero entry 0.
module reg_file_sync
    import reg_file_pkg::*;
#(
    parameter int              WIDTH       = 64,
    parameter int              DEPTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int              SYNC_STAGES = 2,
    parameter bit              ZERO_REG0   = 1'b1,
    parameter bit              BYPASS      = 1'b1,
    localparam int             AW          = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    localparam int NB = WIDTH / 8;

    logic             rst_i;
    logic             waddr_ok;
    logic             wr_ok;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0][AW-1:0]    raddr_p;
    logic [1:0][WIDTH-1:0] rdata_p;

    rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk     (clk),
        .rst_in  (rst),
        .rst_out (rst_i)
    );

    assign ready = ~rst_i;

    // Write port: a write lands on a rising edge with wen=1 and ready=1; the
    // block never back-pressures, so writes offered while ready=0 are dropped.
    always_comb begin
        waddr_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i) && !(ZERO_REG0 && i == 0)) waddr_ok = 1'b1;
        end
    end

    assign wr_ok = wen & ready & (|wstrb) & waddr_ok;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == AW'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        mem[i][8*b +: 8] <= merge_byte(mem[i][8*b +: 8], wdata[8*b +: 8], wstrb[b]);
                    end
                end
            end
        end
    end

    assign raddr_p[0] = raddr1;
    assign raddr_p[1] = raddr2;

    // Forwarding reuses the same byte merge, so a read in the write cycle
    // shows exactly what the entry will hold after the edge.
    always_comb begin
        rdata_p = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (raddr_p[p] == AW'(i) && !(ZERO_REG0 && i == 0)) rdata_p[p] = mem[i];
            end
            if (BYPASS && wr_ok && raddr_p[p] == waddr) begin
                for (int b = 0; b < NB; b++) begin
                    rdata_p[p][8*b +: 8] = merge_byte(rdata_p[p][8*b +: 8], wdata[8*b +: 8], wstrb[b]);
                end
            end
        end
    end

    assign rdata1 = rdata_p[0];
    assign rdata2 = rdata_p[1];

endmodule
